// File: rtl/aes_keysched_pkg.sv
// Shared types, sizing helpers and GF(2^8) primitives for the AES key scheduler.
// Optional feature macro: AES_KEYSCHED_EARLY_READ_EN (see aes_keysched_store).
package aes_keysched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } kstate_t;

  localparam logic [7:0] RCON_INIT = 8'h01;

  function automatic int nk_of(input int k);
    return k / 32;
  endfunction

  function automatic int nr_of(input int k);
    return k / 32 + 6;
  endfunction

  function automatic int nwords_of(input int k);
    return 4 * (nr_of(k) + 1);
  endfunction

  // Multiply by x in GF(2^8), reduction polynomial 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) multiply built from repeated xtime.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int n = 0; n < 8; n++) begin
      if (b[n]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box: multiplicative inverse as b^254 (0 maps to 0), then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] inv;
    p   = b;
    inv = 8'h01;
    for (int n = 0; n < 7; n++) begin
      p   = gmul(p, p);
      inv = gmul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rotword(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_keysched_wordgen.sv
// Combinational next-word generator: w[i] from w[i-Nk], w[i-1], i mod Nk and rcon.
// A single shared SubWord keeps the path to one S-box layer plus two XORs.
module aes_keysched_wordgen
  import aes_keysched_pkg::*;
#(
  parameter int K = 128
) (
  input  logic [31:0] w_old_i,
  input  logic [31:0] w_prev_i,
  input  logic [2:0]  imod_i,
  input  logic [7:0]  rcon_i,
  output logic [31:0] w_new_o
);

  localparam int NK = nk_of(K);

  logic [31:0] sub_in;
  logic [31:0] sub_out;
  logic [31:0] t;

  // Select the transform for this word position and fold it into w[i-Nk].
  always_comb begin
    sub_in  = (imod_i == 3'd0) ? rotword(w_prev_i) : w_prev_i;
    sub_out = subword(sub_in);
    t       = w_prev_i;
    if (imod_i == 3'd0)
      t = sub_out ^ {rcon_i, 24'h000000};
    else if ((NK == 8) && (imod_i == 3'd4))
      t = sub_out;
    w_new_o = w_old_i ^ t;
  end

endmodule

// File: rtl/aes_keysched_store.sv
// AES key scheduler with round-key storage and a registered read port.
// Expands one 32-bit word per cycle into an internal array of Nr+1 round keys.
// Define AES_KEYSCHED_EARLY_READ_EN to let rounds be read during expansion
// as soon as their last word has been written.
module aes_keysched_store
  import aes_keysched_pkg::*;
#(
  parameter int K = 128
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  logic [K-1:0]   key,
  output logic           busy,
  output logic           ready,
  input  logic           rk_req,
  input  logic [3:0]     rk_idx,
  output logic           rk_valid,
  output logic [127:0]   rk,
  output logic           rk_err
);

  localparam int         NK       = nk_of(K);
  localparam int         NW       = nwords_of(K);
  localparam logic [5:0] NK_W     = 6'(NK);
  localparam logic [5:0] LAST_W   = 6'(NW - 1);
  localparam logic [3:0] NR_IDX   = 4'(nr_of(K));
  localparam logic [2:0] IMOD_MAX = 3'(NK - 1);

  if (K != 128 && K != 192 && K != 256) begin : g_bad_k
    $error("aes_keysched_store: K must be 128, 192 or 256");
  end

  kstate_t              state_q, state_d;
  logic [5:0]           i_q, i_d;
  logic [2:0]           imod_q, imod_d;
  logic [7:0]           rcon_q, rcon_d;
  logic [NK-1:0][31:0]  win_q, win_d;     // [0] = w[i-Nk], [NK-1] = w[i-1]
  logic [NK-1:0][31:0]  key_w;
  logic [31:0]          mem_q [NW];
  logic                 wr_load, wr_exp;
  logic [31:0]          w_new;

  logic                 rk_valid_q;
  logic [127:0]         rk_q, rk_d;
  logic                 rk_err_q, rk_err_d;
  logic                 idx_ok, rd_vis;
  logic [5:0]           rd_base;

  aes_keysched_wordgen #(.K(K)) u_wordgen (
    .w_old_i  (win_q[0]),
    .w_prev_i (win_q[NK-1]),
    .imod_i   (imod_q),
    .rcon_i   (rcon_q),
    .w_new_o  (w_new)
  );

  // Split the key into FIPS-197 words, w[0] taken from the top bits.
  always_comb begin
    key_w = '0;
    for (int j = 0; j < NK; j++)
      key_w[j] = key[K-1-32*j -: 32];
  end

  // FSM next state, counters and sliding window; load restarts from any state.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    imod_d  = imod_q;
    rcon_d  = rcon_q;
    win_d   = win_q;
    wr_load = 1'b0;
    wr_exp  = 1'b0;
    if (load) begin
      state_d = EXPAND;
      i_d     = NK_W;
      imod_d  = 3'd0;
      rcon_d  = RCON_INIT;
      win_d   = key_w;
      wr_load = 1'b1;
    end else begin
      case (state_q)
        EXPAND: begin
          wr_exp = 1'b1;
          i_d    = i_q + 6'd1;
          imod_d = (imod_q == IMOD_MAX) ? 3'd0 : imod_q + 3'd1;
          if (imod_q == 3'd0) rcon_d = xtime(rcon_q);
          for (int j = 0; j < NK - 1; j++)
            win_d[j] = win_q[j+1];
          win_d[NK-1] = w_new;
          if (i_q == LAST_W) state_d = DONE;
        end
        default: ;
      endcase
    end
  end

  // State, counter and window registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      i_q     <= 6'd0;
      imod_q  <= 3'd0;
      rcon_q  <= RCON_INIT;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      imod_q  <= imod_d;
      rcon_q  <= rcon_d;
      win_q   <= win_d;
    end
  end

  // Round-key storage; contents are only exposed through the gated read port.
  always_ff @(posedge clk) begin
    if (wr_load) begin
      for (int j = 0; j < NK; j++)
        mem_q[j] <= key_w[j];
    end else if (wr_exp) begin
      mem_q[i_q] <= w_new;
    end
  end

  assign busy  = (state_q == EXPAND);
  assign ready = (state_q == DONE);

  // Read response: visibility uses pre-edge state, so a load in the same
  // cycle still returns the previous key.
  always_comb begin
    rd_base = {rk_idx, 2'b00};
    idx_ok  = (rk_idx <= NR_IDX);
`ifdef AES_KEYSCHED_EARLY_READ_EN
    rd_vis  = idx_ok && ((state_q == DONE) ||
              ((state_q == EXPAND) && (i_q > {rk_idx, 2'b11})));
`else
    rd_vis  = idx_ok && (state_q == DONE);
`endif
    rk_d     = rk_q;
    rk_err_d = rk_err_q;
    if (rk_req) begin
      if (rd_vis) begin
        rk_d     = {mem_q[rd_base], mem_q[rd_base + 6'd1],
                    mem_q[rd_base + 6'd2], mem_q[rd_base + 6'd3]};
        rk_err_d = 1'b0;
      end else begin
        rk_d     = '0;
        rk_err_d = 1'b1;
      end
    end
  end

  // Registered read port; rk holds between requests.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rk_valid_q <= 1'b0;
      rk_q       <= '0;
      rk_err_q   <= 1'b0;
    end else begin
      rk_valid_q <= rk_req;
      rk_q       <= rk_d;
      rk_err_q   <= rk_err_d;
    end
  end

  assign rk_valid = rk_valid_q;
  assign rk       = rk_q;
  assign rk_err   = rk_err_q;

endmodule
